// File: rtl/trace_logger_if.sv
// Capture-stage / system-side signal bundle for trace_logger.
// The logger uses the slave modport; the capture stage drives through master.
interface trace_logger_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(WIDTH);

    logic             EN_I;
    logic             MODE_I;
    logic [AW-1:0]    DELAY_I;
    logic             TRG_EVENT_I;
    logic [PW-1:0]    EVENT_POS_I;
    logic             STORE_I;
    logic [WIDTH-1:0] DATA_I;
    logic             LOAD_I;
    logic [WIDTH-1:0] DATA_O;
    logic             LOAD_O;
    logic             TRG_EVENT_O;
    logic [AW-1:0]    TRIG_ADDR_O;
    logic [PW-1:0]    EVENT_POS_O;
    logic             SYS_WR_I;
    logic [WIDTH-1:0] SYS_DATA_I;
    logic             FULL_O;
    logic             EMPTY_O;

    modport master (
        output EN_I, MODE_I, DELAY_I, TRG_EVENT_I, EVENT_POS_I, STORE_I, DATA_I, LOAD_I,
        output SYS_WR_I, SYS_DATA_I,
        input  DATA_O, LOAD_O, TRG_EVENT_O, TRIG_ADDR_O, EVENT_POS_O, FULL_O, EMPTY_O
    );

    modport slave (
        input  EN_I, MODE_I, DELAY_I, TRG_EVENT_I, EVENT_POS_I, STORE_I, DATA_I, LOAD_I,
        input  SYS_WR_I, SYS_DATA_I,
        output DATA_O, LOAD_O, TRG_EVENT_O, TRIG_ADDR_O, EVENT_POS_O, FULL_O, EMPTY_O
    );
endinterface

// File: rtl/trace_logger.sv
// Trace/stream logger: ring-buffer trace capture with post-trigger delay,
// or a plain FIFO between the system side and the capture stage.
module trace_logger #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input logic           FPGA_CLK_I,
    input logic           RST_I,
    trace_logger_if.slave bus
);
    // state  | meaning
    // IDLE   | disabled, pointers and outputs cleared
    // ARMED  | ring buffer overwriting, waiting for trigger
    // POST   | trigger seen, storing DELAY_I more words
    // DONE   | memory frozen, TRG_EVENT_O raised
    // STREAM | memory used as a FIFO
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(WIDTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, ARMED, POST, DONE, STREAM} state_t;

    state_t           state_q, state_d;
    logic             mode_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    post_cnt_q, post_cnt_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load_q, load_d;
    logic             trg_q, trg_d;
    logic [AW-1:0]    trig_addr_q, trig_addr_d;
    logic [PW-1:0]    evpos_q, evpos_d;
    logic             full_q, full_d, empty_q, empty_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    logic             abort, wr_acc, rd_acc;
    logic [AW-1:0]    post_inc;

    assign abort    = !bus.EN_I || (bus.MODE_I != mode_q);
    assign post_inc = post_cnt_q + AW'(1);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        post_cnt_d  = post_cnt_q;
        count_d     = count_q;
        data_d      = data_q;
        load_d      = 1'b0;
        trg_d       = trg_q;
        trig_addr_d = trig_addr_q;
        evpos_d     = evpos_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;
        mem_wdata   = bus.DATA_I;
        wr_acc      = 1'b0;
        rd_acc      = 1'b0;

        if (abort) begin
            // Disable or a mode change drops everything, including the read word.
            state_d     = IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            post_cnt_d  = '0;
            count_d     = '0;
            data_d      = '0;
            trg_d       = 1'b0;
            trig_addr_d = '0;
            evpos_d     = '0;
        end else begin
            case (state_q)
                IDLE: state_d = bus.MODE_I ? STREAM : ARMED;
                ARMED: begin
                    if (bus.STORE_I) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                    if (bus.TRG_EVENT_I) begin
                        trig_addr_d = wr_ptr_q;
                        evpos_d     = bus.EVENT_POS_I;
                        post_cnt_d  = '0;
                        state_d     = (bus.DELAY_I == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (bus.STORE_I) begin
                        mem_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + AW'(1);
                        post_cnt_d = post_inc;
                        if (post_inc == bus.DELAY_I) state_d = DONE;
                    end
                end
                DONE: trg_d = 1'b1;
                STREAM: begin
                    wr_acc = bus.SYS_WR_I && !full_q;
                    rd_acc = bus.LOAD_I && !empty_q;
                    if (wr_acc) begin
                        mem_we    = 1'b1;
                        mem_wdata = bus.SYS_DATA_I;
                        wr_ptr_d  = wr_ptr_q + AW'(1);
                    end
                    if (rd_acc) begin
                        data_d   = mem_q[rd_ptr_q];
                        load_d   = 1'b1;
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                    if (wr_acc && !rd_acc) count_d = count_q + (AW+1)'(1);
                    if (rd_acc && !wr_acc) count_d = count_q - (AW+1)'(1);
                end
                default: state_d = IDLE;
            endcase

            // Trace-mode read returns the oldest word, before any same-cycle write.
            if (bus.LOAD_I && (state_q == ARMED || state_q == POST || state_q == DONE)) begin
                data_d = mem_q[wr_ptr_q];
                load_d = 1'b1;
            end
        end

        full_d  = (state_d == STREAM) && (count_d == CNT_FULL);
        empty_d = (state_d == STREAM) && (count_d == '0);
    end

    always_ff @(posedge FPGA_CLK_I) begin
        if (RST_I) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            post_cnt_q  <= '0;
            count_q     <= '0;
            data_q      <= '0;
            load_q      <= 1'b0;
            trg_q       <= 1'b0;
            trig_addr_q <= '0;
            evpos_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= bus.MODE_I;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            post_cnt_q  <= post_cnt_d;
            count_q     <= count_d;
            data_q      <= data_d;
            load_q      <= load_d;
            trg_q       <= trg_d;
            trig_addr_q <= trig_addr_d;
            evpos_q     <= evpos_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
        end
    end

    // Storage is not reset; a reset cycle must still block the write.
    always_ff @(posedge FPGA_CLK_I) begin
        if (mem_we && !RST_I) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.DATA_O      = data_q;
    assign bus.LOAD_O      = load_q;
    assign bus.TRG_EVENT_O = trg_q;
    assign bus.TRIG_ADDR_O = trig_addr_q;
    assign bus.EVENT_POS_O = evpos_q;
    assign bus.FULL_O      = full_q;
    assign bus.EMPTY_O     = empty_q;
endmodule
